// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encoding, register ids.
package y86_pkg;
    localparam int NREG = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_ERR  = 2'd2
    } wb_state_t;
endpackage

// File: rtl/writeback_if.sv
// Commit bus from the memory stage, decode read ports, and architectural status outputs.
interface writeback_if;
    logic        wb_valid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [1:0]  stat_in;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] rvalA;
    logic [63:0] rvalB;
    logic [1:0]  stat;
    logic        halted;
    logic [63:0] retired;
    logic [3:0]  last_dstE;
    logic [3:0]  last_dstM;

    modport master (
        output wb_valid, icode, rA, rB, cnd, valE, valM, stat_in, srcA, srcB,
        input  rvalA, rvalB, stat, halted, retired, last_dstE, last_dstM
    );

    modport slave (
        input  wb_valid, icode, rA, rB, cnd, valE, valM, stat_in, srcA, srcB,
        output rvalA, rvalB, stat, halted, retired, last_dstE, last_dstM
    );
endinterface

// File: rtl/regfile.sv
// 15-entry architectural register file: two write ports (M beats E), two async reads.
module regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] data_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] data_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b
);
    logic [63:0] regs [NREG];

    // Reset loads R[i] = i+1; otherwise the M port takes priority over E on the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 64'(i + 1);
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_m && dst_m == 4'(i)) begin
                    regs[i] <= data_m;
                end else if (we_e && dst_e == 4'(i)) begin
                    regs[i] <= data_e;
                end
            end
        end
    end

    // Reads show current contents with no bypass; id F reads as zero.
    always_comb begin
        rval_a = 64'd0;
        rval_b = 64'd0;
        if (src_a != RNONE) rval_a = regs[src_a];
        if (src_b != RNONE) rval_b = regs[src_b];
    end
endmodule

// File: rtl/writeback.sv
// Write-back stage: destination decode, status FSM, retire counter, and the register file.
module writeback
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    writeback_if.slave  wb
);
    wb_state_t   state_reg, state_next;
    stat_t       stat_reg, stat_next;
    logic        halted_reg;
    logic [63:0] retired_reg;
    logic [3:0]  last_dst_e_reg, last_dst_m_reg;
    logic [3:0]  dst_e, dst_m;
    logic        commit, count;

    // Destination decode from icode/cnd/rA/rB.
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (wb.icode)
            I_CMOVXX: dst_e = wb.cnd ? wb.rB : RNONE;
            I_IRMOVQ,
            I_OPQ:    dst_e = wb.rB;
            I_CALL,
            I_RET,
            I_PUSHQ:  dst_e = RRSP;
            I_MRMOVQ: dst_m = wb.rA;
            I_POPQ: begin
                dst_e = RRSP;
                dst_m = wb.rA;
            end
            default: ;
        endcase
    end

    // Next-state logic: only RUN reacts to wb_valid; HALT/ERR are sticky until reset.
    always_comb begin
        state_next = state_reg;
        stat_next  = stat_reg;
        commit     = 1'b0;
        count      = 1'b0;
        if (state_reg == S_RUN && wb.wb_valid) begin
            case (stat_t'(wb.stat_in))
                STAT_AOK: begin
                    if (wb.icode <= I_POPQ) begin
                        commit = 1'b1;
                        count  = 1'b1;
                    end else begin
                        stat_next  = STAT_INS;
                        state_next = S_ERR;
                    end
                end
                STAT_HLT: begin
                    stat_next  = STAT_HLT;
                    state_next = S_HALT;
                    count      = 1'b1;
                end
                default: begin
                    stat_next  = stat_t'(wb.stat_in);
                    state_next = S_ERR;
                end
            endcase
        end
    end

    // Architectural status, retire counter and last-commit destinations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_RUN;
            stat_reg       <= STAT_AOK;
            halted_reg     <= 1'b0;
            retired_reg    <= 64'd0;
            last_dst_e_reg <= RNONE;
            last_dst_m_reg <= RNONE;
        end else begin
            state_reg  <= state_next;
            stat_reg   <= stat_next;
            halted_reg <= (state_next != S_RUN);
            if (count) retired_reg <= retired_reg + 64'd1;
            if (commit) begin
                last_dst_e_reg <= dst_e;
                last_dst_m_reg <= dst_m;
            end
        end
    end

    regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (commit && dst_e != RNONE),
        .dst_e  (dst_e),
        .data_e (wb.valE),
        .we_m   (commit && dst_m != RNONE),
        .dst_m  (dst_m),
        .data_m (wb.valM),
        .src_a  (wb.srcA),
        .src_b  (wb.srcB),
        .rval_a (wb.rvalA),
        .rval_b (wb.rvalB)
    );

    assign wb.stat      = stat_reg;
    assign wb.halted    = halted_reg;
    assign wb.retired   = retired_reg;
    assign wb.last_dstE = last_dst_e_reg;
    assign wb.last_dstM = last_dst_m_reg;
endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed scenarios then random commits against a reference model.
module tb_writeback;
    logic clk;
    logic rst_n;
    writeback_if bus ();

    writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference architectural state.
    logic [63:0] m_reg [15];
    logic [1:0]  m_stat;
    logic        m_term;
    logic [63:0] m_retired;
    logic [3:0]  m_last_e, m_last_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] a);
        if (a == 4'hF) return 64'd0;
        return m_reg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = 64'(i + 1);
        m_stat    = 2'd0;
        m_term    = 1'b0;
        m_retired = 64'd0;
        m_last_e  = 4'hF;
        m_last_m  = 4'hF;
    endtask

    // Which registers an instruction names as destinations.
    task automatic model_dst(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                             input logic c, output logic [3:0] de, output logic [3:0] dm);
        de = 4'hF;
        dm = 4'hF;
        if (ic == 4'h2 && c) de = rb;
        if (ic == 4'h3 || ic == 4'h6) de = rb;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) de = 4'h4;
        if (ic == 4'h5 || ic == 4'hB) dm = ra;
    endtask

    task automatic model_commit(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                                input logic [3:0] rb, input logic c, input logic [63:0] ve,
                                input logic [63:0] vm, input logic [1:0] si);
        logic [3:0] de, dm;
        if (!v || m_term) return;
        if (si == 2'd0) begin
            if (ic <= 4'hB) begin
                model_dst(ic, ra, rb, c, de, dm);
                if (de != 4'hF) m_reg[de] = ve;
                if (dm != 4'hF) m_reg[dm] = vm;   // memory value applied last, so it wins
                m_retired = m_retired + 64'd1;
                m_last_e = de;
                m_last_m = dm;
            end else begin
                m_stat = 2'd3;
                m_term = 1'b1;
            end
        end else if (si == 2'd1) begin
            m_stat = 2'd1;
            m_term = 1'b1;
            m_retired = m_retired + 64'd1;
        end else begin
            m_stat = si;
            m_term = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".stat"},    64'(bus.stat),      64'(m_stat));
        check({tag, ".halted"},  64'(bus.halted),    64'(m_term));
        check({tag, ".retired"}, bus.retired,        m_retired);
        check({tag, ".dstE"},    64'(bus.last_dstE), 64'(m_last_e));
        check({tag, ".dstM"},    64'(bus.last_dstM), 64'(m_last_m));
    endtask

    // One transaction: drive at negedge, check reads before the edge, check state after it.
    task automatic step(input string tag, input logic v, input logic [3:0] ic,
                        input logic [3:0] ra, input logic [3:0] rb, input logic c,
                        input logic [63:0] ve, input logic [63:0] vm, input logic [1:0] si,
                        input logic [3:0] sa, input logic [3:0] sb);
        @(negedge clk);
        bus.wb_valid = v;  bus.icode = ic;  bus.rA = ra;  bus.rB = rb;  bus.cnd = c;
        bus.valE = ve;     bus.valM = vm;   bus.stat_in = si;
        bus.srcA = sa;     bus.srcB = sb;
        #1;
        check({tag, ".rvalA"}, bus.rvalA, m_read(sa));
        check({tag, ".rvalB"}, bus.rvalB, m_read(sb));
        @(posedge clk);
        #1;
        model_commit(v, ic, ra, rb, c, ve, vm, si);
        check_outputs(tag);
        $display("txn %-8s v=%0d ic=%h rA=%h rB=%h cnd=%0d si=%0d -> stat=%0d ret=%0d",
                 tag, v, ic, ra, rb, c, si, bus.stat, bus.retired);
    endtask

    // Reset held across a rising edge with a live commit, which must be dropped.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.wb_valid = 1'b1; bus.icode = 4'h6; bus.rB = 4'h0; bus.stat_in = 2'd0;
        bus.valE = 64'hDEAD; bus.srcA = 4'h3; bus.srcB = 4'hF;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        check({tag, ".rvalA"}, bus.rvalA, 64'd4);
        check({tag, ".rvalB"}, bus.rvalB, 64'd0);
        @(posedge clk);
        #1;
        check({tag, ".r0held"}, bus.rvalA, 64'd4);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        $display("txn %-8s reset", tag);
    endtask

    initial begin
        logic [3:0]  ic, ra, rb, sa, sb;
        logic [1:0]  si;
        logic [63:0] ve, vm;
        int          term_cycles;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.wb_valid = 1'b0; bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
        bus.valE = '0; bus.valM = '0; bus.stat_in = 2'd0; bus.srcA = 4'hF; bus.srcB = 4'hF;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        step("idle", 0, 4'h6, 4'hF, 4'h2, 0, 64'h77, 0, 2'd0, 4'h3, 4'hF);
        check("idle.ret", bus.retired, 64'd0);
        step("opq", 1, 4'h6, 4'hF, 4'h2, 0, 64'h55, 0, 2'd0, 4'h2, 4'h3);
        step("opq_rd", 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 2'd0, 4'h2, 4'hF);
        check("opq.R2", bus.rvalA, 64'h55);
        check("opq.ret", bus.retired, 64'd1);
        check("opq.dstE", 64'(bus.last_dstE), 64'd2);
        step("cmov0", 1, 4'h2, 4'hF, 4'h6, 0, 64'h9, 0, 2'd0, 4'h6, 4'hF);
        step("cmov0rd", 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 2'd0, 4'h6, 4'hF);
        check("cmov0.R6", bus.rvalA, 64'd7);
        step("cmov1", 1, 4'h2, 4'hF, 4'h6, 1, 64'h9, 0, 2'd0, 4'h6, 4'hF);
        step("cmov1rd", 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 2'd0, 4'h6, 4'hF);
        check("cmov1.R6", bus.rvalA, 64'h9);
        step("poprsp", 1, 4'hB, 4'h4, 4'hF, 0, 64'h100, 64'hAB, 2'd0, 4'h4, 4'hF);
        step("poprd", 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 2'd0, 4'h4, 4'hF);
        check("pop.R4", bus.rvalA, 64'hAB);
        step("adr", 1, 4'h6, 4'hF, 4'h1, 0, 64'h3, 0, 2'd2, 4'h1, 4'hF);
        check("adr.stat", 64'(bus.stat), 64'd2);
        step("postadr", 1, 4'h6, 4'hF, 4'h1, 0, 64'h3, 0, 2'd0, 4'h1, 4'hF);
        step("adrrd", 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 2'd0, 4'h1, 4'hF);
        do_reset("rst1");
        step("badic", 1, 4'hC, 4'hF, 4'h1, 0, 64'h3, 0, 2'd0, 4'h1, 4'hF);
        check("badic.stat", 64'(bus.stat), 64'd3);
        do_reset("rst2");
        step("halt", 1, 4'h0, 4'hF, 4'hF, 0, 0, 0, 2'd1, 4'h0, 4'hE);
        check("halt.ret", bus.retired, 64'd1);
        step("posthlt", 1, 4'h3, 4'hF, 4'h0, 0, 64'h5, 0, 2'd0, 4'h0, 4'hE);
        do_reset("rst3");

        // Random commits; reset periodically so most cycles run in RUN.
        term_cycles = 0;
        for (int n = 0; n < 500; n++) begin
            ic = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            ra = 4'($urandom);
            rb = 4'($urandom);
            sa = 4'($urandom);
            sb = 4'($urandom);
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            si = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            step("rnd", 1'($urandom_range(0, 3) != 0), ic, ra, rb, 1'($urandom), ve, vm, si, sa, sb);
            if (m_term) term_cycles++;
            if (term_cycles > 3) begin
                do_reset("rndrst");
                term_cycles = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/writeback.md
# writeback

Y86-64 write-back stage and architectural register file for the sequential processor. It sits after the memory stage and commits `valE`/`valM` into the 15-entry register file on the clock edge. It provides the combinational read ports that the decode stage samples. It also owns the processor status state machine (`AOK`/`HLT`/`ADR`/`INS`) and a retired-instruction counter, so it is the single point where architectural state changes.

## Interface
Parameters
- `NREG`, 15: architectural registers, indices 0..14; index `4'hF` = none.

Ports
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wb_valid`, in, 1: an instruction is presented for commit this cycle.
- `icode`, in, 4: instruction code.
- `rA`, `rB`, in, 4: register specifiers from fetch.
- `cnd`, in, 1: condition result from execute; used by cmovxx only.
- `valE`, in, 64: ALU result.
- `valM`, in, 64: memory read data.
- `stat_in`, in, 2: status from memory stage.
- `srcA`, `srcB`, in, 4: read addresses from decode.
- `rvalA`, `rvalB`, out, 64: combinational read data.
- `stat`, out, 2: registered processor status.
- `halted`, out, 1: registered; 1 in any terminal state.
- `retired`, out, 64: registered count of committed instructions.
- `last_dstE`, `last_dstM`, out, 4: registered destinations of the last commit.

## Operation
- Status encoding: `AOK`=0, `HLT`=1, `ADR`=2, `INS`=3.
- Destination decode (combinational):
  - cmovxx (2): `dstE` = `cnd` ? `rB` : F.
  - irmovq (3), OPq (6): `dstE` = `rB`.
  - call (8), ret (9), pushq (A), popq (B): `dstE` = 4 (`%rsp`).
  - mrmovq (5), popq (B): `dstM` = `rA`.
  - All other icodes: `dstE` = `dstM` = F.
- Writes: `R[dstE]` ← `valE` when `dstE` ≠ F. `R[dstM]` ← `valM` when `dstM` ≠ F.
  - If `dstE` == `dstM`, `valM` wins. For popq %rsp, %rsp receives the popped value.
- Reads: `rvalX` = `R[srcX]`, or 0 when `srcX` = F. The value is the current array contents, with no write bypass; a write becomes visible after the edge.
- FSM states and transitions:
  - RUN: on `wb_valid`:
    - `stat_in`=AOK and icode ≤ B: commit writes, `retired`++, update `last_dst*`.
    - `stat_in`=AOK and icode > B: no writes, `stat`←INS, go ERR.
    - `stat_in`=HLT: no writes, `stat`←HLT, go HALT. The halt instruction is counted as retired.
    - `stat_in`=ADR/INS: no writes, `stat`←`stat_in`, go ERR. Not counted.
  - HALT, ERR: terminal. `wb_valid` is ignored, with no writes and no count change. Only reset exits.
- `retired` wraps from 2^64−1 to 0.

## Timing
- Commit latency: 1 edge. `rvalA`/`rvalB` reflect a write on the cycle after `wb_valid`.
- `stat`/`halted` update on the same edge as the triggering `wb_valid`.
- Reset (asynchronous, any cycle, including mid-commit):
  - `R[i]` = i+1 for i = 0..14.
  - `stat` = AOK, `halted` = 0, `retired` = 0, `last_dstE` = `last_dstM` = F, FSM = RUN.
  - A commit coincident with reset assertion is discarded.
- `wb_valid` low: no state change.

## Structure
- Shared package `y86_pkg`: icode constants (`I_HALT`..`I_POPQ`), stat encoding, `RNONE` = 4'hF, `RRSP` = 4'h4.
- One sub-module, `regfile`: 15×64 array with 2 write ports (E, M with M priority), 2 async read ports, and asynchronous reset to i+1.
- FSM, destination decode and counter stay in `writeback`.

## Test plan
- Reset, then `srcA`=3, `srcB`=F → `rvalA`=4, `rvalB`=0. Also `stat`=AOK, `retired`=0.
- OPq, `rB`=2, `valE`=0x55, AOK → next cycle `R[2]`=0x55, `retired`=1, `last_dstE`=2.
- cmovxx, `rB`=6, `cnd`=0 → `R[6]` stays 7. Same with `cnd`=1, `valE`=9 → `R[6]`=9.
- popq, `rA`=4, `valE`=0x100, `valM`=0xAB → `R[4]`=0xAB.
- `stat_in`=ADR → `stat`=ADR, `halted`=1, no writes. A following OPq → no writes, `retired` unchanged.
- icode=C with AOK → `stat`=INS. Then assert `rst_n`=0 mid-cycle → all outputs return to reset values immediately.
